// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, ALU operator enum and the issue/retire payload types.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // ALU_ADD must stay at encoding 0 so a cleared D register presents ADD.
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_XOR, ALU_OR, ALU_AND, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_EQ, ALU_NE, ALU_LT, ALU_GE, ALU_LTU, ALU_GEU
    } alu_op;

    typedef struct packed {
        alu_op           alu_operator;
        logic [XLEN-1:0] op_a;
        logic [XLEN-1:0] op_b;
        logic [4:0]      rd;
        logic            we;
        logic            branch;
        logic            illegal;
        logic [XLEN-1:0] target;
    } issue_t;

    typedef struct packed {
        logic [4:0]      rd;
        logic            we;
        logic            branch;
        logic            taken;
        logic            illegal;
        logic [XLEN-1:0] target;
        logic [XLEN-1:0] result;
    } retire_t;

endpackage

// File: rtl/alu_issue_if.sv
// alu_issue_if: instruction input, ALU drive/return and retire output bundle.
interface alu_issue_if;
    import alu_pkg::*;

    logic            in_valid_i;
    logic            in_ready_o;
    logic [XLEN-1:0] instr_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] rs1_data_i;
    logic [XLEN-1:0] rs2_data_i;
    alu_op           alu_operator_o;
    logic [XLEN-1:0] alu_op_a_o;
    logic [XLEN-1:0] alu_op_b_o;
    logic [XLEN-1:0] alu_result_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [4:0]      out_rd_o;
    logic            out_we_o;
    logic [XLEN-1:0] out_result_o;
    logic            out_branch_o;
    logic            out_taken_o;
    logic [XLEN-1:0] out_target_o;
    logic            out_illegal_o;
    logic [XLEN-1:0] retire_cnt_o;

    modport slave (
        input  in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, alu_result_i, out_ready_i,
        output in_ready_o, alu_operator_o, alu_op_a_o, alu_op_b_o, out_valid_o, out_rd_o,
               out_we_o, out_result_o, out_branch_o, out_taken_o, out_target_o,
               out_illegal_o, retire_cnt_o
    );

    modport master (
        output in_valid_i, instr_i, pc_i, rs1_data_i, rs2_data_i, alu_result_i, out_ready_i,
        input  in_ready_o, alu_operator_o, alu_op_a_o, alu_op_b_o, out_valid_o, out_rd_o,
               out_we_o, out_result_o, out_branch_o, out_taken_o, out_target_o,
               out_illegal_o, retire_cnt_o
    );

endinterface

// File: rtl/alu_issue_decoder.sv
// alu_issue_decoder: combinational RV32I OP/OP-IMM/LUI/AUIPC/BRANCH decode into issue_t.
module alu_issue_decoder
    import alu_pkg::*;
(
    input  logic [XLEN-1:0] instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    output issue_t          issue_o
);
    logic [6:0]      opc, f7;
    logic [2:0]      f3;
    logic [XLEN-1:0] imm_i, imm_u, imm_b;
    logic            is_op, is_imm, is_lui, is_auipc, is_br;
    logic            f7_zero, f7_alt, legal;
    alu_op           arith_op, br_op;

    always_comb begin
        opc      = instr_i[6:0];
        f3       = instr_i[14:12];
        f7       = instr_i[31:25];
        imm_i    = {{20{instr_i[31]}}, instr_i[31:20]};
        imm_u    = {instr_i[31:12], 12'b0};
        imm_b    = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
        is_op    = opc == OPC_OP;
        is_imm   = opc == OPC_OP_IMM;
        is_lui   = opc == OPC_LUI;
        is_auipc = opc == OPC_AUIPC;
        is_br    = opc == OPC_BRANCH;
        f7_zero  = f7 == 7'b0000000;
        f7_alt   = f7 == 7'b0100000;
        legal    = (is_op && (f7_zero || (f7_alt && (f3 == 3'b000 || f3 == 3'b101))))
                || (is_imm && (f3 == 3'b001 ? f7_zero : f3 == 3'b101 ? (f7_zero || f7_alt) : 1'b1))
                || is_lui || is_auipc
                || (is_br && f3[2:1] != 2'b01);
    end

    always_comb begin
        case (f3)
            3'b000:  arith_op = (is_op && f7_alt) ? ALU_SUB : ALU_ADD;
            3'b001:  arith_op = ALU_SLL;
            3'b010:  arith_op = ALU_SLT;
            3'b011:  arith_op = ALU_SLTU;
            3'b100:  arith_op = ALU_XOR;
            3'b101:  arith_op = f7_alt ? ALU_SRA : ALU_SRL;
            3'b110:  arith_op = ALU_OR;
            default: arith_op = ALU_AND;
        endcase
    end

    always_comb begin
        case (f3)
            3'b000:  br_op = ALU_EQ;
            3'b001:  br_op = ALU_NE;
            3'b100:  br_op = ALU_LT;
            3'b101:  br_op = ALU_GE;
            3'b110:  br_op = ALU_LTU;
            default: br_op = ALU_GEU;
        endcase
    end

    // Illegal entries collapse to ADD 0,0 so the ALU sees a harmless operation.
    always_comb begin
        issue_o.alu_operator = !legal ? ALU_ADD : is_br ? br_op : (is_op || is_imm) ? arith_op : ALU_ADD;
        issue_o.op_a         = (!legal || is_lui) ? '0 : is_auipc ? pc_i : rs1_data_i;
        issue_o.op_b         = !legal ? '0 : (is_lui || is_auipc) ? imm_u : is_imm ? imm_i : rs2_data_i;
        issue_o.rd           = instr_i[11:7];
        issue_o.we           = legal && !is_br && instr_i[11:7] != 5'd0;
        issue_o.branch       = legal && is_br;
        issue_o.illegal      = !legal;
        issue_o.target       = pc_i + imm_b;
    end

endmodule

// File: rtl/alu_issue.sv
// alu_issue: two-deep issue/retire pipeline around an external combinational ALU.
module alu_issue
    import alu_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_i,
    alu_issue_if.slave bus
);
    issue_t          dec, d_q, d_d;
    retire_t         o_q, o_d, o_new;
    logic            d_valid_q, d_valid_d, o_valid_q, o_valid_d;
    logic [XLEN-1:0] cnt_q, cnt_d;
    logic            in_ready, in_fire, out_fire, d_to_o;

    alu_issue_decoder u_dec (
        .instr_i   (bus.instr_i),
        .pc_i      (bus.pc_i),
        .rs1_data_i(bus.rs1_data_i),
        .rs2_data_i(bus.rs2_data_i),
        .issue_o   (dec)
    );

    always_comb begin
        in_ready     = !d_valid_q || !o_valid_q || bus.out_ready_i;
        in_fire      = bus.in_valid_i && in_ready;
        out_fire     = o_valid_q && bus.out_ready_i;
        d_to_o       = d_valid_q && (!o_valid_q || bus.out_ready_i);
        d_valid_d    = in_fire || (d_valid_q && !d_to_o);
        d_d          = in_fire ? dec : d_q;
        o_valid_d    = d_to_o || (o_valid_q && !bus.out_ready_i);
        o_new.rd      = d_q.rd;
        o_new.we      = d_q.we;
        o_new.branch  = d_q.branch;
        o_new.taken   = d_q.branch && bus.alu_result_i[0];
        o_new.illegal = d_q.illegal;
        o_new.target  = d_q.target;
        o_new.result  = (d_q.branch || d_q.illegal) ? '0 : bus.alu_result_i;
        o_d          = d_to_o ? o_new : o_q;
        cnt_d        = cnt_q + {{(XLEN-1){1'b0}}, out_fire};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            d_valid_q <= 1'b0;
            o_valid_q <= 1'b0;
            d_q       <= '0;
            o_q       <= '0;
            cnt_q     <= '0;
        end else begin
            d_valid_q <= d_valid_d;
            o_valid_q <= o_valid_d;
            d_q       <= d_d;
            o_q       <= o_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.in_ready_o     = in_ready;
    assign bus.alu_operator_o = d_q.alu_operator;
    assign bus.alu_op_a_o     = d_q.op_a;
    assign bus.alu_op_b_o     = d_q.op_b;
    assign bus.out_valid_o    = o_valid_q;
    assign bus.out_rd_o       = o_q.rd;
    assign bus.out_we_o       = o_q.we;
    assign bus.out_result_o   = o_q.result;
    assign bus.out_branch_o   = o_q.branch;
    assign bus.out_taken_o    = o_q.taken;
    assign bus.out_target_o   = o_q.target;
    assign bus.out_illegal_o  = o_q.illegal;
    assign bus.retire_cnt_o   = cnt_q;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: scoreboard bench; expected retire data comes from RV32I instruction semantics.
module tb_alu_issue;
    import alu_pkg::*;

    typedef struct packed {
        logic [4:0]  rd;
        logic        we;
        logic        branch;
        logic        taken;
        logic        illegal;
        logic [31:0] target;
        logic [31:0] result;
    } exp_t;

    logic clk = 0, rst = 1;
    int   checks = 0, errors = 0;
    int   model_cnt = 0;
    bit   rand_rdy = 0;
    bit   stall_prev = 0;
    logic [95:0] snap_prev;
    exp_t exp_q[$];

    alu_issue_if bus ();
    alu_issue dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [31:0] alu_model(alu_op op, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        case (op)
            ALU_ADD:  r = a + b;
            ALU_SUB:  r = a - b;
            ALU_XOR:  r = a ^ b;
            ALU_OR:   r = a | b;
            ALU_AND:  r = a & b;
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = $signed(a) >>> b[4:0];
            ALU_SLT, ALU_LT: r = {31'b0, $signed(a) < $signed(b)};
            ALU_SLTU, ALU_LTU: r = {31'b0, a < b};
            ALU_EQ:   r = {31'b0, a == b};
            ALU_NE:   r = {31'b0, a != b};
            ALU_GE:   r = {31'b0, $signed(a) >= $signed(b)};
            default:  r = {31'b0, a >= b};
        endcase
        return r;
    endfunction

    assign bus.alu_result_i = alu_model(bus.alu_operator_o, bus.alu_op_a_o, bus.alu_op_b_o);

    function automatic logic [31:0] arith(logic [2:0] f3, logic sub, logic sra, logic [31:0] a, logic [31:0] b);
        logic [31:0] r;
        case (f3)
            3'd0: r = sub ? a - b : a + b;
            3'd1: r = a << b[4:0];
            3'd2: r = {31'b0, $signed(a) < $signed(b)};
            3'd3: r = {31'b0, a < b};
            3'd4: r = a ^ b;
            3'd5: if (sra) r = $signed(a) >>> b[4:0]; else r = a >> b[4:0];
            3'd6: r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    function automatic exp_t ref_model(logic [31:0] ins, logic [31:0] pc, logic [31:0] a, logic [31:0] b);
        exp_t        e;
        logic        ok;
        logic [6:0]  f7 = ins[31:25];
        logic [2:0]  f3 = ins[14:12];
        logic [31:0] imm_i = {{20{ins[31]}}, ins[31:20]};
        logic [31:0] imm_b = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        e = '0;
        ok = 0;
        e.rd = ins[11:7];
        case (ins[6:0])
            7'h33: begin
                ok = f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5));
                e.result = arith(f3, f7[5], f7[5], a, b);
            end
            7'h13: begin
                ok = (f3 == 1) ? f7 == 0 : (f3 == 5) ? (f7 == 0 || f7 == 7'h20) : 1'b1;
                e.result = arith(f3, 1'b0, f7[5], a, imm_i);
            end
            7'h37: begin ok = 1; e.result = {ins[31:12], 12'h0}; end
            7'h17: begin ok = 1; e.result = pc + {ins[31:12], 12'h0}; end
            7'h63: begin
                ok = f3 != 2 && f3 != 3;
                e.branch = 1;
                e.target = pc + imm_b;
                case (f3)
                    3'd0: e.taken = a == b;
                    3'd1: e.taken = a != b;
                    3'd4: e.taken = $signed(a) < $signed(b);
                    3'd5: e.taken = $signed(a) >= $signed(b);
                    3'd6: e.taken = a < b;
                    default: e.taken = a >= b;
                endcase
            end
            default: ok = 0;
        endcase
        if (!ok) begin
            e = '0;
            e.illegal = 1;
        end
        e.we = ok && !e.branch && ins[11:7] != 0;
        return e;
    endfunction

    task automatic chk(string name, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: push on input handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        logic [95:0] snap;
        exp_t e;
        snap = {23'b0, bus.out_rd_o, bus.out_we_o, bus.out_branch_o, bus.out_taken_o,
                bus.out_illegal_o, bus.out_target_o, bus.out_result_o};
        if (rst) begin
            exp_q.delete();
            model_cnt = 0;
            stall_prev = 0;
        end else begin
            if (bus.in_valid_i && bus.in_ready_o)
                exp_q.push_back(ref_model(bus.instr_i, bus.pc_i, bus.rs1_data_i, bus.rs2_data_i));
            chk("retire_cnt", 96'(bus.retire_cnt_o), 96'(model_cnt));
            if (stall_prev) begin
                chk("stall_valid", 96'(bus.out_valid_o), 96'd1);
                chk("stall_stable", snap, snap_prev);
            end
            if (bus.out_valid_o && bus.out_ready_i) begin
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected", 96'd1, 96'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_illegal", 96'(bus.out_illegal_o), 96'(e.illegal));
                    chk("sb_we", 96'(bus.out_we_o), 96'(e.we));
                    chk("sb_branch", 96'(bus.out_branch_o), 96'(e.branch));
                    chk("sb_taken", 96'(bus.out_taken_o), 96'(e.taken));
                    chk("sb_result", 96'(bus.out_result_o), 96'(e.result));
                    if (e.branch) chk("sb_target", 96'(bus.out_target_o), 96'(e.target));
                    if (!e.branch && !e.illegal) chk("sb_rd", 96'(bus.out_rd_o), 96'(e.rd));
                end
                model_cnt++;
            end
            stall_prev = bus.out_valid_o && !bus.out_ready_i;
        end
        snap_prev = snap;
    end

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) bus.out_ready_i = $urandom_range(0, 3) != 0;
    end

    task automatic issue(logic [31:0] ins, logic [31:0] pc, logic [31:0] a, logic [31:0] b);
        bit acc;
        bus.in_valid_i = 1;
        bus.instr_i    = ins;
        bus.pc_i       = pc;
        bus.rs1_data_i = a;
        bus.rs2_data_i = b;
        for (int n = 0; ; n++) begin
            @(negedge clk);
            acc = bus.in_ready_o;
            @(posedge clk);
            #1;
            if (acc) break;
            if (n > 200) begin
                chk("issue_timeout", 96'd1, 96'd0);
                break;
            end
        end
        bus.in_valid_i = 0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int n = 0; exp_q.size() != 0 || bus.out_valid_o; n++) begin
            if (n > 100) begin
                chk("drain_timeout", 96'(exp_q.size()), 96'd0);
                break;
            end
            step();
        end
    endtask

    initial begin
        logic [31:0] ins, a, b, base;
        logic [12:0] bimm;
        logic [6:0]  f7;
        bus.in_valid_i = 0;
        bus.instr_i = 0;
        bus.pc_i = 0;
        bus.rs1_data_i = 0;
        bus.rs2_data_i = 0;
        bus.out_ready_i = 1;
        repeat (3) step();
        chk("rst_out_valid", 96'(bus.out_valid_o), 96'd0);
        chk("rst_in_ready", 96'(bus.in_ready_o), 96'd1);
        chk("rst_cnt", 96'(bus.retire_cnt_o), 96'd0);
        chk("rst_operator", 96'(bus.alu_operator_o), 96'(ALU_ADD));
        chk("rst_result", 96'(bus.out_result_o), 96'd0);
        rst = 0;
        step();

        // ADD x3, x1, x2: two-cycle latency
        issue({7'h00, 5'd2, 5'd1, 3'd0, 5'd3, 7'h33}, 32'h0, 32'd5, 32'd7);
        chk("add_lat_d", 96'(bus.out_valid_o), 96'd0);
        step();
        chk("add_valid", 96'(bus.out_valid_o), 96'd1);
        chk("add_rd", 96'(bus.out_rd_o), 96'd3);
        chk("add_we", 96'(bus.out_we_o), 96'd1);
        chk("add_result", 96'(bus.out_result_o), 96'd12);
        step();
        chk("add_cnt", 96'(bus.retire_cnt_o), 96'd1);

        // SRAI x5, x6, 4
        issue({7'h20, 5'd4, 5'd6, 3'd5, 5'd5, 7'h13}, 32'h0, 32'h8000_0000, 32'h0);
        chk("srai_op", 96'(bus.alu_operator_o), 96'(ALU_SRA));
        chk("srai_shamt", 96'(bus.alu_op_b_o[4:0]), 96'd4);
        step();
        chk("srai_result", 96'(bus.out_result_o), 96'hF800_0000);

        // BLT with -1 < 1, pc 0x100, offset -8
        bimm = 13'h1FF8;
        issue({bimm[12], bimm[10:5], 5'd2, 5'd1, 3'd4, bimm[4:1], bimm[11], 7'h63},
              32'h100, 32'hFFFF_FFFF, 32'd1);
        step();
        chk("blt_branch", 96'(bus.out_branch_o), 96'd1);
        chk("blt_taken", 96'(bus.out_taken_o), 96'd1);
        chk("blt_target", 96'(bus.out_target_o), 96'h0F8);
        chk("blt_we", 96'(bus.out_we_o), 96'd0);
        drain();

        // Four ADDs with the output stalled for three cycles
        base = bus.retire_cnt_o;
        bus.out_ready_i = 0;
        issue({7'h00, 5'd2, 5'd1, 3'd0, 5'd4, 7'h33}, 32'h0, 32'd1, 32'd10);
        issue({7'h00, 5'd2, 5'd1, 3'd0, 5'd5, 7'h33}, 32'h0, 32'd2, 32'd20);
        chk("full_in_ready", 96'(bus.in_ready_o), 96'd0);
        chk("full_out_valid", 96'(bus.out_valid_o), 96'd1);
        bus.in_valid_i = 1;
        step();
        bus.out_ready_i = 1;
        issue({7'h00, 5'd2, 5'd1, 3'd0, 5'd6, 7'h33}, 32'h0, 32'd3, 32'd30);
        issue({7'h00, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33}, 32'h0, 32'd4, 32'd40);
        drain();
        chk("stream_cnt", 96'(bus.retire_cnt_o), 96'(base + 4));

        // Illegal opcode, then ADD to x0
        base = bus.retire_cnt_o;
        issue(32'h0000_007F, 32'h0, 32'd9, 32'd9);
        issue({7'h00, 5'd2, 5'd1, 3'd0, 5'd0, 7'h33}, 32'h0, 32'd9, 32'd9);
        drain();
        chk("illegal_cnt", 96'(bus.retire_cnt_o), 96'(base + 2));

        // Reset with both stages full
        bus.out_ready_i = 0;
        issue({7'h00, 5'd2, 5'd1, 3'd0, 5'd8, 7'h33}, 32'h0, 32'd1, 32'd1);
        issue({7'h00, 5'd2, 5'd1, 3'd0, 5'd9, 7'h33}, 32'h0, 32'd2, 32'd2);
        chk("prerst_in_ready", 96'(bus.in_ready_o), 96'd0);
        #2 rst = 1;
        #1;
        chk("midrst_out_valid", 96'(bus.out_valid_o), 96'd0);
        chk("midrst_in_ready", 96'(bus.in_ready_o), 96'd1);
        chk("midrst_cnt", 96'(bus.retire_cnt_o), 96'd0);
        chk("midrst_operator", 96'(bus.alu_operator_o), 96'(ALU_ADD));
        step();
        rst = 0;
        bus.out_ready_i = 1;
        issue({7'h00, 5'd2, 5'd1, 3'd0, 5'd7, 7'h33}, 32'h0, 32'd100, 32'd23);
        chk("postrst_lat_d", 96'(bus.out_valid_o), 96'd0);
        step();
        chk("postrst_valid", 96'(bus.out_valid_o), 96'd1);
        chk("postrst_result", 96'(bus.out_result_o), 96'd123);
        step();
        chk("postrst_cnt", 96'(bus.retire_cnt_o), 96'd1);

        // Randomized stream with random backpressure
        rand_rdy = 1;
        for (int i = 0; i < 400; i++) begin
            ins = $urandom;
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            case ($urandom_range(0, 2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            case ($urandom_range(0, 5))
                0: begin ins[6:0] = 7'h33; ins[31:25] = f7; end
                1: begin ins[6:0] = 7'h13; ins[31:25] = f7; end
                2: ins[6:0] = 7'h37;
                3: ins[6:0] = 7'h17;
                4: ins[6:0] = 7'h63;
                default: ;
            endcase
            issue(ins, $urandom, a, b);
            if ($urandom_range(0, 3) == 0) step();
        end
        rand_rdy = 0;
        @(posedge clk);
        #2 bus.out_ready_i = 1;
        drain();
        chk("final_queue_empty", 96'(exp_q.size()), 96'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1);
    end

endmodule
